hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage RV32 core. Generates the execute-stage operand forwarding selects, detects load-use hazards, holds a multi-cycle operation in execute for a fixed latency, and flushes on taken branches and jumps. It also keeps a saturating stall-cycle counter. It sits beside the execute stage and drives the stall and flush enables of every pipeline register.

---
 rtl/rv_pkg.sv | 32 +++
 rtl/md_seq.sv | 65 ++++++
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32 pipeline control blocks.
//   FWD_RF/FWD_W/FWD_M : execute-stage operand forward selects
//   WB_MEM             : writeback select encoding for load data
//   mdState_e          : multi-cycle sequencer states
//   fwdSel()           : forward-select priority function (M over W)
package rv_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam logic [1:0] WB_MEM = 2'b01;

   typedef enum logic {IDLE, BUSY} mdState_e;

   // x0 is never forwarded; the newer value in M beats the older one in W.
   function automatic logic [1:0] fwdSel(input logic       wrM,
                                         input logic [4:0] rdM,
                                         input logic       wrW,
                                         input logic [4:0] rdW,
                                         input logic [4:0] rs);
      logic [1:0] sel;
      sel = FWD_RF;
      if (wrM && (rdM != 5'd0) && (rdM == rs)) begin
         sel = FWD_M;
      end else if (wrW && (rdW != 5'd0) && (rdW == rs)) begin
         sel = FWD_W;
      end
      return sel;
   endfunction

endpackage

// File: rtl/md_seq.sv
// Multi-cycle execute sequencer. Holds a multi-cycle op in execute for MD_LAT
// cycles: MD_LAT-1 stalled cycles followed by one md_done cycle.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   md_reqE   in   instruction in execute is a multi-cycle op
//   md_stall  out  hold front of pipe and bubble EX-MEM this cycle
//   md_done   out  final execute cycle of the multi-cycle op
module md_seq
   import rv_pkg::*;
#(
   parameter int unsigned MD_LAT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic md_reqE,
   output logic md_stall,
   output logic md_done
);

   // The IDLE cycle that accepts the request is the first stalled cycle.
   localparam logic [3:0] CNT_LOAD = 4'(MD_LAT - 2);

   mdState_e   stateQ, stateD;
   logic [3:0] cntQ, cntD;

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ <= IDLE;
         cntQ   <= 4'd0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
      end
   end

   always_comb begin
      stateD   = stateQ;
      cntD     = cntQ;
      md_stall = 1'b0;
      md_done  = 1'b0;
      if (!rst) begin
         unique case (stateQ)
            IDLE: begin
               if (md_reqE) begin
                  md_stall = 1'b1;
                  cntD     = CNT_LOAD;
                  stateD   = BUSY;
               end
            end
            BUSY: begin
               if (cntQ != 4'd0) begin
                  md_stall = 1'b1;
                  cntD     = cntQ - 4'd1;
               end else begin
                  // Return to IDLE so a request still high now is not retaken.
                  md_done = 1'b1;
                  stateD  = IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage RV32 core.
// Build option: HAZARD_FWD_EN enables E-stage operand forwarding; without it
// every RAW hazard against E or M stalls decode instead.
// Ports:
//   clk, rst                        clock; synchronous active-high reset
//   rs1D, rs2D                      decode source registers
//   rs1E, rs2E                      execute source registers
//   rdE, rdM, rdW                   destination registers in E/M/W
//   regwriteE, regwriteM, regwriteW register write enables in E/M/W
//   wbselE                          writeback select in execute
//   pcselE                          taken branch/jump resolved in execute
//   md_reqE                         execute holds a multi-cycle op
//   forwardAE, forwardBE            operand forward selects (00 RF, 01 W, 10 M)
//   stallF, stallD, stallE          hold PC / IF-ID / ID-EX
//   flushD, flushE, flushM          bubble into IF-ID / ID-EX / EX-MEM
//   md_done                         last execute cycle of a multi-cycle op
//   stall_cycles                    saturating count of stallF cycles
module hazard_ctrl
   import rv_pkg::*;
#(
   parameter int unsigned MD_LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1D,
   input  logic [4:0]  rs2D,
   input  logic [4:0]  rs1E,
   input  logic [4:0]  rs2E,
   input  logic [4:0]  rdE,
   input  logic [4:0]  rdM,
   input  logic [4:0]  rdW,
   input  logic        regwriteE,
   input  logic        regwriteM,
   input  logic        regwriteW,
   input  logic [1:0]  wbselE,
   input  logic        pcselE,
   input  logic        md_reqE,
   output logic [1:0]  forwardAE,
   output logic [1:0]  forwardBE,
   output logic        stallF,
   output logic        stallD,
   output logic        stallE,
   output logic        flushD,
   output logic        flushE,
   output logic        flushM,
   output logic        md_done,
   output logic [31:0] stall_cycles
);

   logic        mdStall;
   logic        hazD;
   logic        matchE;
   logic        matchM;
   logic [31:0] stallCntQ;

   md_seq #(
      .MD_LAT (MD_LAT)
   ) u_md_seq (
      .clk      (clk),
      .rst      (rst),
      .md_reqE  (md_reqE),
      .md_stall (mdStall),
      .md_done  (md_done)
   );

   assign matchE = regwriteE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
   assign matchM = regwriteM && (rdM != 5'd0) && ((rdM == rs1D) || (rdM == rs2D));

`ifdef HAZARD_FWD_EN
   // Only a load in E cannot be forwarded in time; everything else bypasses.
   assign hazD = matchE && (wbselE == WB_MEM);

   logic unusedMatchM;
   assign unusedMatchM = matchM;

   always_comb begin
      forwardAE = FWD_RF;
      forwardBE = FWD_RF;
      if (!rst) begin
         forwardAE = fwdSel(regwriteM, rdM, regwriteW, rdW, rs1E);
         forwardBE = fwdSel(regwriteM, rdM, regwriteW, rdW, rs2E);
      end
   end
`else
   // No bypass network: any producer still in E or M must reach writeback
   // first. W needs nothing since the register file writes early.
   assign hazD = matchE || matchM;

   assign forwardAE = FWD_RF;
   assign forwardBE = FWD_RF;

   logic unusedFwdIn;
   assign unusedFwdIn = ^{rs1E, rs2E, rdW, regwriteW, wbselE};
`endif

   // Priority: multi-cycle hold, then redirect, then decode hazard.
   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      flushM = 1'b0;
      if (!rst) begin
         if (mdStall) begin
            // Never flush E here: that would kill the op being held.
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
         end else if (pcselE) begin
            flushD = 1'b1;
            flushE = 1'b1;
         end else if (hazD) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stallCntQ <= 32'd0;
      end else if (stallF && (stallCntQ != 32'hFFFF_FFFF)) begin
         stallCntQ <= stallCntQ + 32'd1;
      end
   end

   assign stall_cycles = rst ? 32'd0 : stallCntQ;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl. Expectations adapt to whether
// HAZARD_FWD_EN is defined for the build.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
   localparam bit FwdEn = 1'b1;
`else
   localparam bit FwdEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic        regwriteE, regwriteM, regwriteW;
   logic [1:0]  wbselE;
   logic        pcselE, md_reqE;
   logic [1:0]  forwardAE, forwardBE;
   logic        stallF, stallD, stallE, flushD, flushE, flushM, md_done;
   logic [31:0] stall_cycles;

   int numVectors = 0;
   int numMiscompares = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .MD_LAT (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rs1D         (rs1D),
      .rs2D         (rs2D),
      .rs1E         (rs1E),
      .rs2E         (rs2E),
      .rdE          (rdE),
      .rdM          (rdM),
      .rdW          (rdW),
      .regwriteE    (regwriteE),
      .regwriteM    (regwriteM),
      .regwriteW    (regwriteW),
      .wbselE       (wbselE),
      .pcselE       (pcselE),
      .md_reqE      (md_reqE),
      .forwardAE    (forwardAE),
      .forwardBE    (forwardBE),
      .stallF       (stallF),
      .stallD       (stallD),
      .stallE       (stallE),
      .flushD       (flushD),
      .flushE       (flushE),
      .flushM       (flushM),
      .md_done      (md_done),
      .stall_cycles (stall_cycles)
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      numVectors++;
      if (got !== exp) begin
         numMiscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearIn();
      rs1D = 5'd0; rs2D = 5'd0; rs1E = 5'd0; rs2E = 5'd0;
      rdE = 5'd0; rdM = 5'd0; rdW = 5'd0;
      regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
      wbselE = 2'b00; pcselE = 1'b0; md_reqE = 1'b0;
   endtask

   // Packs the six stall/flush outputs as {stallF,stallD,stallE,flushD,flushE,flushM}.
   function automatic logic [5:0] ctl();
      return {stallF, stallD, stallE, flushD, flushE, flushM};
   endfunction

   initial begin
      clearIn();
      rst = 1'b1;
      // Reset cycle with hazards present on the inputs: everything must read 0.
      md_reqE = 1'b1; regwriteE = 1'b1; wbselE = 2'b01; rdE = 5'd7; rs2D = 5'd7;
      rs1E = 5'd5; rdM = 5'd5; regwriteM = 1'b1;
      #2;
      checkVal("rst_ctl", 32'(ctl()), 32'h0);
      checkVal("rst_fwdA", 32'(forwardAE), 32'h0);
      checkVal("rst_done", 32'(md_done), 32'h0);
      tick();
      checkVal("rst_cnt", stall_cycles, 32'd0);
      clearIn();
      rst = 1'b0;
      #1;
      checkVal("idle_ctl", 32'(ctl()), 32'h0);

      // Forwarding priority
      rs1E = 5'd5; rdM = 5'd5; regwriteM = 1'b1; rdW = 5'd5; regwriteW = 1'b1;
      #1;
      checkVal("fwdA_M", 32'(forwardAE), FwdEn ? 32'd2 : 32'd0);
      regwriteM = 1'b0;
      #1;
      checkVal("fwdA_W", 32'(forwardAE), FwdEn ? 32'd1 : 32'd0);
      regwriteM = 1'b1; rdM = 5'd0; rdW = 5'd0;
      #1;
      checkVal("fwdA_x0", 32'(forwardAE), 32'd0);
      rs2E = 5'd9; rdM = 5'd9; rdW = 5'd9;
      #1;
      checkVal("fwdB_M", 32'(forwardBE), FwdEn ? 32'd2 : 32'd0);
      checkVal("fwdA_miss", 32'(forwardAE), 32'd0);
      clearIn();
      tick();

      // Load-use: one stalled cycle
      regwriteE = 1'b1; wbselE = 2'b01; rdE = 5'd7; rs2D = 5'd7;
      #1;
      checkVal("lu_ctl", 32'(ctl()), 32'b110010);
      tick();
      clearIn();
      #1;
      checkVal("lu_release", 32'(ctl()), 32'h0);
      checkVal("lu_cnt", stall_cycles, 32'd1);

      // Load into x0 is never a hazard
      regwriteE = 1'b1; wbselE = 2'b01; rdE = 5'd0; rs1D = 5'd0;
      #1;
      checkVal("lu_x0", 32'(ctl()), 32'h0);
      // ALU result in E: hazard only without forwarding
      rdE = 5'd4; rs1D = 5'd4; wbselE = 2'b00;
      #1;
      checkVal("alu_E", 32'(ctl()), FwdEn ? 32'h0 : 32'b110010);
      clearIn();

      // Branch beats load-use
      regwriteE = 1'b1; wbselE = 2'b01; rdE = 5'd7; rs2D = 5'd7; pcselE = 1'b1;
      #1;
      checkVal("br_lu", 32'(ctl()), 32'b000110);
      clearIn();

      // RAW against M
      regwriteM = 1'b1; rdM = 5'd3; rs1D = 5'd3;
      #1;
      checkVal("rawM_ctl", 32'(ctl()), FwdEn ? 32'h0 : 32'b110010);
      checkVal("rawM_fwdA", 32'(forwardAE), 32'd0);
      clearIn();
      tick();
      checkVal("cnt_before_md", stall_cycles, 32'd1);

      // Multi-cycle op, request held for four cycles; a load-use in cycle 1
      // must not flush E.
      md_reqE = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) begin
            regwriteE = 1'b1; wbselE = 2'b01; rdE = 5'd7; rs2D = 5'd7;
         end else begin
            regwriteE = 1'b0; rdE = 5'd0; rs2D = 5'd0;
         end
         #1;
         checkVal($sformatf("md_ctl%0d", c), 32'(ctl()), (c < 3) ? 32'b111001 : 32'h0);
         checkVal($sformatf("md_done%0d", c), 32'(md_done), (c == 3) ? 32'd1 : 32'd0);
         tick();
      end
      clearIn();
      #1;
      checkVal("md_after", 32'(ctl()), 32'h0);
      checkVal("md_after_done", 32'(md_done), 32'd0);
      checkVal("md_cnt", stall_cycles, 32'd4);
      tick();

      // Reset during the second BUSY cycle
      md_reqE = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      md_reqE = 1'b0;
      #1;
      checkVal("mdrst_ctl", 32'(ctl()), 32'h0);
      tick();
      rst = 1'b0;
      #1;
      checkVal("mdrst_idle", 32'(ctl()), 32'h0);
      checkVal("mdrst_done", 32'(md_done), 32'd0);
      checkVal("mdrst_cnt", stall_cycles, 32'd0);
      tick();
      checkVal("mdrst_idle2", 32'(md_done), 32'd0);

      // Fresh request after the reset runs the full sequence again
      md_reqE = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         checkVal($sformatf("md2_stallE%0d", c), 32'(stallE), (c < 3) ? 32'd1 : 32'd0);
         checkVal($sformatf("md2_done%0d", c), 32'(md_done), (c == 3) ? 32'd1 : 32'd0);
         tick();
      end
      md_reqE = 1'b0;
      #1;
      checkVal("md2_cnt", stall_cycles, 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
      $finish;
   end

endmodule
